// File: rtl/monster_fire_pkg.sv
// Shared types and constants for the monster fire scheduler.
//   fire_state_t : scheduler FSM states (IDLE, SCAN, GRANT)
//   LFSR_W       : width of the pseudo-random generator
//   LFSR_TAPS    : feedback mask for taps 8,6,5,4 (bit 7 = tap 8)
//   lfsr_step()  : one Fibonacci shift of the LFSR
package monster_fire_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } fire_state_t;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    // Shift left, feeding back the XOR of the tapped bits into bit 0.
    // x^8+x^6+x^5+x^4+1 is primitive, so a nonzero seed never reaches zero.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fire_lfsr.sv
// 8-bit Fibonacci LFSR used to randomise the round-robin pointer skip.
//   clk       : system clock
//   reset     : asynchronous active-high reset, loads SEED
//   i_advance : one shift per high cycle (driven by startOfFrame)
//   o_value   : current LFSR state
module fire_lfsr
    import monster_fire_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_advance,
    output logic [LFSR_W-1:0] o_value
);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (i_advance) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/monster_fire_scheduler.sv
// Global enemy fire scheduler: one shared frame-based cooldown, round-robin
// selection over alive monsters with a pseudo-random pointer skip, and a cap
// on missiles in flight.
//   clk, reset     : clock, asynchronous active-high reset
//   startOfFrame   : one-cycle frame pulse (cooldown tick, LFSR advance)
//   enable         : game running; low keeps the scheduler from granting
//   alive          : per-monster active mask
//   missile_retire : one-cycle pulse when an enemy missile disappears
//   fire_grant     : one-hot, one-cycle fire pulse
//   grant_valid    : high with fire_grant
//   grant_index    : index of the granted monster
//   slots_in_use   : missiles currently in flight
module monster_fire_scheduler
    import monster_fire_pkg::*;
#(
    parameter int                MONSTER_AMOUNT  = 20,
    parameter int                MAX_SHOTS       = 6,
    parameter int                COOLDOWN_FRAMES = 30,
    parameter logic [LFSR_W-1:0] LFSR_SEED       = 8'hA5,
    parameter int                IDX_W           = $clog2(MONSTER_AMOUNT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startOfFrame,
    input  logic                          enable,
    input  logic [MONSTER_AMOUNT-1:0]     alive,
    input  logic                          missile_retire,
    output logic [MONSTER_AMOUNT-1:0]     fire_grant,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_index,
    output logic [$clog2(MAX_SHOTS+1)-1:0] slots_in_use
);

    localparam int SLOT_W = $clog2(MAX_SHOTS + 1);
    localparam int CD_W   = $clog2(COOLDOWN_FRAMES + 1);
    localparam int CNT_W  = $clog2(MONSTER_AMOUNT + 1);

    fire_state_t               r_state, w_state_next;
    logic [IDX_W-1:0]          r_rr_ptr, w_rr_ptr_next;
    logic [IDX_W-1:0]          r_sel, w_sel_next;
    logic [CNT_W-1:0]          r_scan_cnt, w_scan_cnt_next;
    logic [CD_W-1:0]           r_cooldown, w_cooldown_next;
    logic [SLOT_W-1:0]         r_slots, w_slots_next;
    logic [MONSTER_AMOUNT-1:0] r_fire_grant, w_fire_grant_next;
    logic                      r_grant_valid, w_grant_valid_next;
    logic [IDX_W-1:0]          r_grant_index, w_grant_index_next;

    logic [LFSR_W-1:0]         w_lfsr;
    logic                      w_unused_lfsr_bits;
    logic [MONSTER_AMOUNT-1:0] w_onehot;
    logic [IDX_W:0]            w_ptr_sum;
    logic [IDX_W-1:0]          w_ptr_adv;
    logic                      w_slot_inc, w_slot_dec;

    fire_lfsr #(
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .i_advance (startOfFrame),
        .o_value   (w_lfsr)
    );

    // Only the two low LFSR bits steer the pointer skip.
    assign w_unused_lfsr_bits = ^w_lfsr[LFSR_W-1:2];

    // Decode of the candidate currently under examination.
    for (genvar gi = 0; gi < MONSTER_AMOUNT; gi++) begin : g_onehot
        assign w_onehot[gi] = (r_rr_ptr == IDX_W'(gi));
    end

    // sel + 1 + skip(0..3) stays below 2*MONSTER_AMOUNT because
    // MONSTER_AMOUNT >= 4, so one conditional subtract is enough.
    assign w_ptr_sum = (IDX_W+1)'(r_sel) + (IDX_W+1)'(w_lfsr[1:0]) + (IDX_W+1)'(1);
    assign w_ptr_adv = (w_ptr_sum >= (IDX_W+1)'(MONSTER_AMOUNT))
                     ? IDX_W'(w_ptr_sum - (IDX_W+1)'(MONSTER_AMOUNT))
                     : IDX_W'(w_ptr_sum);

    assign w_slot_inc = (r_state == GRANT);
    assign w_slot_dec = missile_retire && (r_slots != '0);

    always_comb begin
        w_state_next       = r_state;
        w_rr_ptr_next      = r_rr_ptr;
        w_sel_next         = r_sel;
        w_scan_cnt_next    = r_scan_cnt;
        w_fire_grant_next  = '0;
        w_grant_valid_next = 1'b0;
        w_grant_index_next = '0;
        w_cooldown_next    = r_cooldown;
        w_slots_next       = r_slots;

        case (r_state)
            IDLE: begin
                if (enable && (r_cooldown == '0) &&
                    (r_slots < SLOT_W'(MAX_SHOTS)) && (alive != '0)) begin
                    w_state_next    = SCAN;
                    w_scan_cnt_next = '0;
                end
            end
            SCAN: begin
                if (!enable || (alive == '0) ||
                    (r_scan_cnt == CNT_W'(MONSTER_AMOUNT))) begin
                    // Cooldown is still zero, so the next IDLE cycle retries.
                    w_state_next = IDLE;
                end else if (alive[r_rr_ptr]) begin
                    // Grant outputs are registered so they line up with GRANT.
                    w_state_next       = GRANT;
                    w_sel_next         = r_rr_ptr;
                    w_fire_grant_next  = w_onehot;
                    w_grant_valid_next = 1'b1;
                    w_grant_index_next = r_rr_ptr;
                end else begin
                    w_rr_ptr_next   = (r_rr_ptr == IDX_W'(MONSTER_AMOUNT - 1))
                                    ? '0 : r_rr_ptr + IDX_W'(1);
                    w_scan_cnt_next = r_scan_cnt + CNT_W'(1);
                end
            end
            GRANT: begin
                w_state_next  = IDLE;
                w_rr_ptr_next = w_ptr_adv;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Reload in GRANT takes priority over a coinciding frame tick.
        if (r_state == GRANT) begin
            w_cooldown_next = CD_W'(COOLDOWN_FRAMES);
        end else if (startOfFrame && (r_cooldown != '0)) begin
            w_cooldown_next = r_cooldown - CD_W'(1);
        end

        if (w_slot_inc && !w_slot_dec) begin
            w_slots_next = r_slots + SLOT_W'(1);
        end else if (w_slot_dec && !w_slot_inc) begin
            w_slots_next = r_slots - SLOT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_sel         <= '0;
            r_scan_cnt    <= '0;
            r_cooldown    <= CD_W'(COOLDOWN_FRAMES);
            r_slots       <= '0;
            r_fire_grant  <= '0;
            r_grant_valid <= 1'b0;
            r_grant_index <= '0;
        end else begin
            r_state       <= w_state_next;
            r_rr_ptr      <= w_rr_ptr_next;
            r_sel         <= w_sel_next;
            r_scan_cnt    <= w_scan_cnt_next;
            r_cooldown    <= w_cooldown_next;
            r_slots       <= w_slots_next;
            r_fire_grant  <= w_fire_grant_next;
            r_grant_valid <= w_grant_valid_next;
            r_grant_index <= w_grant_index_next;
        end
    end

    assign fire_grant   = r_fire_grant;
    assign grant_valid  = r_grant_valid;
    assign grant_index  = r_grant_index;
    assign slots_in_use = r_slots;

endmodule

// File: tb/tb_monster_fire_scheduler.sv
module tb_monster_fire_scheduler;

    localparam int MA    = 20;
    localparam int MS    = 2;
    localparam int CD    = 3;
    localparam int IDX_W = 5;
    localparam logic [MA-1:0] ALL = 20'hFFFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          startOfFrame;
    logic          enable;
    logic [MA-1:0] alive;
    logic          missile_retire;
    logic [MA-1:0] fire_grant;
    logic          grant_valid;
    logic [IDX_W-1:0] grant_index;
    logic [1:0]    slots_in_use;

    monster_fire_scheduler #(
        .MONSTER_AMOUNT  (MA),
        .MAX_SHOTS       (MS),
        .COOLDOWN_FRAMES (CD),
        .LFSR_SEED       (8'hA5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .enable         (enable),
        .alive          (alive),
        .missile_retire (missile_retire),
        .fire_grant     (fire_grant),
        .grant_valid    (grant_valid),
        .grant_index    (grant_index),
        .slots_in_use   (slots_in_use)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   grant_count = 0;
    int   exp_q[$];
    int   m_ptr = 0;
    logic [7:0] m_lfsr;
    bit   seen[MA];
    bit   fair_on = 1'b0;

    // Reference LFSR: taps 8,6,5,4, advanced by each frame pulse.
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 8'hA5;
        else if (startOfFrame) m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Scoreboard: pop the expected index whenever the DUT grants.
    always @(negedge clk) begin
        if (reset) begin
            m_ptr = 0;
        end else if (grant_valid) begin
            int e;
            logic [MA-1:0] oh;
            grant_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_grant: got index %0d, required no grant", grant_index);
            end else begin
                e = exp_q.pop_front();
                oh = '0;
                oh[e] = 1'b1;
                if (grant_index !== IDX_W'(e) || fire_grant !== oh) begin
                    n_fail++;
                    $display("FAIL grant_match: got index %0d onehot %h, required index %0d onehot %h",
                             grant_index, fire_grant, e, oh);
                end
                m_ptr = e + 1 + int'(m_lfsr[1:0]);
                if (m_ptr >= MA) m_ptr -= MA;
                if (fair_on) seen[e] = 1'b1;
            end
        end else begin
            n_checks++;
            if (fire_grant !== '0 || grant_index !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs: got onehot %h index %0d, required 0 0", fire_grant, grant_index);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
    endtask

    task automatic frame_gap();
        pulse_sof();
        tick(25);
    endtask

    function automatic int first_alive();
        for (int k = 0; k < MA; k++) begin
            int i;
            i = (m_ptr + k) % MA;
            if (alive[i]) return i;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        exp_q.delete();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // Counts negedges until grant_valid; returns max+1 when none arrives.
    task automatic wait_grant_cycles(input int max, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc <= max) begin
            @(negedge clk);
            cyc++;
            if (grant_valid) got = 1'b1;
        end
    endtask

    task automatic do_grant(input int max_frames);
        int start;
        bit got;
        start = grant_count;
        got = 1'b0;
        exp_q.push_back(first_alive());
        for (int f = 0; f <= max_frames && !got; f++) begin
            for (int c = 0; c < 26 && !got; c++) begin
                tick(1);
                if (grant_count != start) got = 1'b1;
            end
            if (!got && f < max_frames) pulse_sof();
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL grant_timeout: got no grant, required one within %0d frames", max_frames);
            void'(exp_q.pop_back());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; startOfFrame = 1'b0; enable = 1'b1; alive = ALL; missile_retire = 1'b0;
        tick(3);
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", grant_valid); end
        n_checks++; if (fire_grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %h, required 0", fire_grant); end
        n_checks++; if (grant_index !== '0) begin n_fail++; $display("FAIL reset_index: got %0d, required 0", grant_index); end
        n_checks++; if (slots_in_use !== 2'd0) begin n_fail++; $display("FAIL reset_slots: got %0d, required 0", slots_in_use); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_first_grant();
        int cyc;
        exp_q.push_back(first_alive());
        frame_gap();
        frame_gap();
        n_checks++; if (grant_count != 0) begin n_fail++; $display("FAIL early_grant: got %0d grants, required 0", grant_count); end
        pulse_sof();
        wait_grant_cycles(30, cyc);
        n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL first_latency: got %0d cycles, required 3", cyc); end
        tick(3);
        n_checks++; if (slots_in_use !== 2'd1) begin n_fail++; $display("FAIL first_slots: got %0d, required 1", slots_in_use); end
    endtask

    task automatic test_scan_skip();
        int cyc;
        apply_reset();
        alive = 20'h00010;
        exp_q.push_back(first_alive());
        frame_gap();
        frame_gap();
        pulse_sof();
        wait_grant_cycles(40, cyc);
        n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL skip_latency: got %0d cycles, required 7", cyc); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL one_cycle_pulse: got %b, required 0", grant_valid); end
        tick(1);
    endtask

    task automatic test_max_shots();
        int start;
        apply_reset();
        alive = ALL;
        do_grant(4);
        do_grant(4);
        n_checks++; if (slots_in_use !== 2'd2) begin n_fail++; $display("FAIL full_slots: got %0d, required 2", slots_in_use); end
        start = grant_count;
        repeat (10) frame_gap();
        n_checks++; if (grant_count != start) begin n_fail++; $display("FAIL blocked_at_full: got %0d grants, required 0", grant_count - start); end
        missile_retire = 1'b1; tick(1); missile_retire = 1'b0; tick(1);
        n_checks++; if (slots_in_use !== 2'd1) begin n_fail++; $display("FAIL after_retire: got %0d, required 1", slots_in_use); end
        do_grant(4);
        tick(2);
        n_checks++; if (slots_in_use !== 2'd2) begin n_fail++; $display("FAIL third_slots: got %0d, required 2", slots_in_use); end
    endtask

    task automatic test_retire_edges();
        apply_reset();
        alive = ALL;
        do_grant(4);
        exp_q.push_back(first_alive());
        frame_gap();
        frame_gap();
        pulse_sof();
        tick(2);
        n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL grant_cycle_align: got %b, required 1", grant_valid); end
        missile_retire = 1'b1; tick(1); missile_retire = 1'b0; tick(1);
        n_checks++; if (slots_in_use !== 2'd1) begin n_fail++; $display("FAIL retire_with_grant: got %0d, required 1", slots_in_use); end
        missile_retire = 1'b1; tick(1); missile_retire = 1'b0; tick(1);
        n_checks++; if (slots_in_use !== 2'd0) begin n_fail++; $display("FAIL retire_to_zero: got %0d, required 0", slots_in_use); end
        missile_retire = 1'b1; tick(1); missile_retire = 1'b0; tick(1);
        n_checks++; if (slots_in_use !== 2'd0) begin n_fail++; $display("FAIL retire_at_zero: got %0d, required 0", slots_in_use); end
    endtask

    task automatic test_alive_drop();
        int start;
        int cyc;
        apply_reset();
        alive = 20'h80000;
        exp_q.push_back(first_alive());
        frame_gap();
        frame_gap();
        pulse_sof();
        tick(3);
        alive = '0;
        start = grant_count;
        tick(30);
        n_checks++; if (grant_count != start) begin n_fail++; $display("FAIL no_grant_alive0: got %0d grants, required 0", grant_count - start); end
        alive = 20'h80000;
        wait_grant_cycles(MA + 3, cyc);
        n_checks++; if (cyc > MA + 2) begin n_fail++; $display("FAIL restore_latency: got %0d cycles, required <= %0d", cyc, MA + 2); end
        tick(2);
    endtask

    task automatic test_reset_mid_scan();
        int start;
        int cyc;
        apply_reset();
        alive = ALL;
        frame_gap();
        frame_gap();
        pulse_sof();
        tick(1);
        start = grant_count;
        reset = 1'b1;
        tick(1);
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b, required 0", grant_valid); end
        n_checks++; if (fire_grant !== '0) begin n_fail++; $display("FAIL midreset_grant: got %h, required 0", fire_grant); end
        n_checks++; if (grant_index !== '0) begin n_fail++; $display("FAIL midreset_index: got %0d, required 0", grant_index); end
        n_checks++; if (slots_in_use !== 2'd0) begin n_fail++; $display("FAIL midreset_slots: got %0d, required 0", slots_in_use); end
        tick(1);
        reset = 1'b0;
        tick(1);
        exp_q.push_back(first_alive());
        frame_gap();
        frame_gap();
        n_checks++; if (grant_count != start) begin n_fail++; $display("FAIL cooldown_reloaded: got %0d grants, required 0", grant_count - start); end
        pulse_sof();
        wait_grant_cycles(30, cyc);
        n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL post_reset_latency: got %0d cycles, required 3", cyc); end
        tick(2);
    endtask

    task automatic test_fairness();
        apply_reset();
        alive = ALL;
        fair_on = 1'b1;
        for (int g = 0; g < 200; g++) begin
            do_grant(4);
            missile_retire = 1'b1; tick(1); missile_retire = 1'b0; tick(1);
        end
        fair_on = 1'b0;
        for (int i = 0; i < MA; i++) begin
            n_checks++;
            if (!seen[i]) begin n_fail++; $display("FAIL fairness: index %0d got 0 grants, required >= 1", i); end
        end
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_scan_skip();
        test_max_shots();
        test_retire_edges();
        test_alive_drop();
        test_reset_mid_scan();
        test_fairness();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
